// File: rtl/cube.sv
// cube: sequential unsigned integer cube, result = x_i**3.
// One shift-add multiplier stage is iterated twice: MUL1 forms x*x,
// MUL2 forms (x*x)*x. Handshake matches the cube-root block.
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     synchronous active-high reset
//   x_i     operand (N bits), sampled only on the edge that accepts start
//   start   request, accepted only while idle
//   result  registered cube of the last accepted operand (3N bits)
//   busy    registered, high while a computation is in progress
//
// Build option:
//   CUBE_EARLY_EXIT_EN  when defined, each multiply phase ends as soon as
//                       the multiplier shift register runs out of set bits
//                       (latency 2*max(1, msb_index(x)+1)); otherwise
//                       each phase always takes N steps (latency 2N).
//
// States:
//   IDLE | waiting for start, all state held
//   MUL1 | shift-add steps computing x*x
//   MUL2 | shift-add steps computing (x*x)*x
module cube #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     x_i,
  input  logic             start,
  output logic [3*N-1:0]   result,
  output logic             busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     xr, xr_n;
  logic [N-1:0]     b, b_n;
  logic [3*N-1:0]   a, a_n;
  logic [3*N-1:0]   part, part_n;
  logic [3*N-1:0]   result_n;
  logic [CW-1:0]    ctr, ctr_n;
  logic             busy_n;
  logic [3*N-1:0]   sum;
  logic             last;

  // Accumulation for the current step; the last step's addition is
  // included in the value handed to the next phase / result.
  assign sum = part + (b[0] ? a : '0);

`ifdef CUBE_EARLY_EXIT_EN
  // Ends on the step consuming the highest set multiplier bit; a zero
  // multiplier also ends after exactly one step.
  assign last = ((b >> 1) == '0);
`else
  assign last = (ctr == CW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xr     <= '0;
      a      <= '0;
      b      <= '0;
      part   <= '0;
      ctr    <= '0;
      result <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      xr     <= xr_n;
      a      <= a_n;
      b      <= b_n;
      part   <= part_n;
      ctr    <= ctr_n;
      result <= result_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    xr_n     = xr;
    a_n      = a;
    b_n      = b;
    part_n   = part;
    ctr_n    = ctr;
    result_n = result;
    busy_n   = busy;

    case (state)
      IDLE: begin
        if (start) begin
          xr_n    = x_i;
          a_n     = {{(2*N){1'b0}}, x_i};
          b_n     = x_i;
          part_n  = '0;
          ctr_n   = '0;
          state_n = MUL1;
          busy_n  = 1'b1;
        end
      end

      MUL1, MUL2: begin
        if (last) begin
          if (state == MUL1) begin
            a_n     = sum;
            b_n     = xr;
            part_n  = '0;
            ctr_n   = '0;
            state_n = MUL2;
          end else begin
            result_n = sum;
            busy_n   = 1'b0;
            state_n  = IDLE;
          end
        end else begin
          part_n = sum;
          a_n    = a << 1;
          b_n    = b >> 1;
          ctr_n  = ctr + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
